// File: rtl/stage_if_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, FSM state
// encoding and the byte-address helper used by the fetch sequencer.
package stage_if_pkg;

    localparam int ADDR_W         = 32;
    localparam int INST_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int IC_INDEX_W_DEF = 6;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Address of byte idx within the word starting at base (32-bit modulo).
    function automatic logic [ADDR_W-1:0] byte_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [1:0]        idx);
        return base + {{(ADDR_W-2){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/stage_if_if.sv
// Byte-wide instruction memory bus between the fetch stage (master) and the
// memory system (slave). One request per byte; data returns on mem_valid.
interface stage_if_if;
    import stage_if_pkg::*;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic              mem_valid;
    logic [BYTE_W-1:0] mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_valid,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_valid,
        output mem_data
    );

endinterface

// File: rtl/stage_if_icache.sv
// Direct-mapped word cache for the fetch stage, compiled only when the
// IF_ICACHE_EN macro is defined. Read port is combinational, write port is
// synchronous. Only the valid bits are reset; tag/data contents are don't-care
// until their line is marked valid.
`ifdef IF_ICACHE_EN
module stage_if_icache
    import stage_if_pkg::*;
#(
    parameter int IC_INDEX_W = IC_INDEX_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_pc,
    output logic              rd_hit,
    output logic [INST_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_pc,
    input  logic [INST_W-1:0] wr_data
);

    localparam int LINES = 1 << IC_INDEX_W;
    localparam int TAG_W = ADDR_W - IC_INDEX_W - 2;

    logic [LINES-1:0]      line_vld;
    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [INST_W-1:0]     data_mem [LINES];
    logic [IC_INDEX_W-1:0] rd_idx;
    logic [IC_INDEX_W-1:0] wr_idx;
    logic [3:0]            pc_lsb_unused;

    assign rd_idx        = rd_pc[IC_INDEX_W+1:2];
    assign wr_idx        = wr_pc[IC_INDEX_W+1:2];
    assign pc_lsb_unused = {rd_pc[1:0], wr_pc[1:0]};

    assign rd_hit  = line_vld[rd_idx] && (tag_mem[rd_idx] == rd_pc[ADDR_W-1:IC_INDEX_W+2]);
    assign rd_data = data_mem[rd_idx];

    // Valid bits: cleared by reset, set when a completed fetch fills the line.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            line_vld <= '0;
        end else if (wr_en) begin
            line_vld[wr_idx] <= 1'b1;
        end
    end

    // Tag and data storage: written on fill, never reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_pc[ADDR_W-1:IC_INDEX_W+2];
            data_mem[wr_idx] <= wr_data;
        end
    end

endmodule
`endif

// File: rtl/stage_if.sv
// Instruction-fetch stage. Assembles a 32-bit little-endian instruction from
// four byte requests on the memory bus, tags it with the branch-buffer
// prediction for its PC and holds it until downstream accepts it. A jump
// redirects the PC at any time; a byte already in flight is dropped.
// Optional feature: define IF_ICACHE_EN to add a direct-mapped word cache
// (stage_if_icache) that turns a hit into a single-cycle fetch.
module stage_if
    import stage_if_pkg::*;
#(
    parameter int IC_INDEX_W = IC_INDEX_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] btb_pc,
    input  logic [ADDR_W-1:0] btb_next,
    input  logic              btb_pred,
    stage_if_if.master        mem,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_pred,
    output logic [ADDR_W-1:0] inst_pred_pc
);

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [1:0]        cnt, cnt_n;
    logic              drop, drop_n;
    logic              inst_valid_n;
    logic [INST_W-1:0] inst_n;
    logic [ADDR_W-1:0] inst_pc_n;
    logic              inst_pred_n;
    logic [ADDR_W-1:0] inst_pred_pc_n;
    logic              req;
    logic              enter_hold;
    logic              fill_we;
    logic              ic_hit;
    logic [INST_W-1:0] ic_data;

    assign btb_pc       = pc;
    assign mem.mem_addr = byte_addr(pc, cnt);
    // The state register sits at FETCH while reset is held, so the request is
    // masked until reset is released.
    assign mem.mem_req  = req && reset;

`ifdef IF_ICACHE_EN
    stage_if_icache #(
        .IC_INDEX_W (IC_INDEX_W)
    ) u_icache (
        .clock   (clock),
        .reset   (reset),
        .rd_pc   (pc),
        .rd_hit  (ic_hit),
        .rd_data (ic_data),
        .wr_en   (fill_we),
        .wr_pc   (pc),
        .wr_data ({mem.mem_data, inst[23:0]})
    );
`else
    logic [IC_INDEX_W:0] ic_unused;
    assign ic_hit    = 1'b0;
    assign ic_data   = '0;
    assign ic_unused = {fill_we, pc[IC_INDEX_W+1:2]};
`endif

    // Next-state and bus outputs; jump is applied last so it overrides all.
    always_comb begin
        state_n        = state;
        pc_n           = pc;
        cnt_n          = cnt;
        drop_n         = drop;
        inst_valid_n   = inst_valid;
        inst_n         = inst;
        inst_pc_n      = inst_pc;
        inst_pred_n    = inst_pred;
        inst_pred_pc_n = inst_pred_pc;
        req            = 1'b0;
        enter_hold     = 1'b0;
        fill_we        = 1'b0;

        case (state)
            ST_FETCH: begin
                if (drop) begin
                    // Wait for the orphaned byte of an aborted fetch and discard it.
                    if (mem.mem_valid) begin
                        drop_n = 1'b0;
                    end
                end else if (ic_hit && (cnt == 2'd0)) begin
                    inst_n     = ic_data;
                    enter_hold = 1'b1;
                end else begin
                    req = 1'b1;
                    if (mem.mem_ready) begin
                        state_n = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem.mem_valid) begin
                    inst_n[{cnt, 3'b000} +: BYTE_W] = mem.mem_data;
                    if (cnt == 2'd3) begin
                        enter_hold = 1'b1;
                        fill_we    = 1'b1;
                    end else begin
                        cnt_n   = cnt + 2'd1;
                        state_n = ST_FETCH;
                    end
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    pc_n         = inst_pred_pc;
                    cnt_n        = 2'd0;
                    inst_valid_n = 1'b0;
                    state_n      = ST_FETCH;
                end
            end
            default: begin
                state_n = ST_FETCH;
            end
        endcase

        if (enter_hold) begin
            state_n        = ST_HOLD;
            inst_valid_n   = 1'b1;
            inst_pc_n      = pc;
            inst_pred_n    = btb_pred;
            inst_pred_pc_n = btb_next;
        end

        if (jump) begin
            state_n        = ST_FETCH;
            pc_n           = jump_target;
            cnt_n          = 2'd0;
            inst_valid_n   = 1'b0;
            inst_n         = inst;
            inst_pc_n      = inst_pc;
            inst_pred_n    = inst_pred;
            inst_pred_pc_n = inst_pred_pc;
            req            = 1'b0;
            fill_we        = 1'b0;
            // A byte still outstanding from WAIT must not land in the new fetch;
            // one returning in this very cycle is simply ignored.
            if ((state == ST_WAIT) && !mem.mem_valid) begin
                drop_n = 1'b1;
            end
        end
    end

    // State register for the FSM, PC, byte counter and the held instruction.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_FETCH;
            pc           <= '0;
            cnt          <= 2'd0;
            drop         <= 1'b0;
            inst_valid   <= 1'b0;
            inst         <= '0;
            inst_pc      <= '0;
            inst_pred    <= 1'b0;
            inst_pred_pc <= '0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            cnt          <= cnt_n;
            drop         <= drop_n;
            inst_valid   <= inst_valid_n;
            inst         <= inst_n;
            inst_pc      <= inst_pc_n;
            inst_pred    <= inst_pred_n;
            inst_pred_pc <= inst_pred_pc_n;
        end
    end

endmodule

// File: tb/tb_stage_if.sv
// Scoreboard bench for stage_if: stimulus pushes expected instructions and
// expected byte-request addresses; a memory responder checks each request and
// a monitor checks each newly presented instruction.
module tb_stage_if;

`ifdef IF_ICACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
        logic [31:0] ppc;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] btb_pc;
    logic [31:0] btb_next;
    logic        btb_pred;
    logic [31:0] btb_tgt;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_pred;
    logic [31:0] inst_pred_pc;

    int checks = 0;
    int errors = 0;
    int resp_delay = 0;

    exp_t        exp_q[$];
    logic [31:0] exp_addr_q[$];

    stage_if_if mem_bus();

    stage_if dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .jump         (jump),
        .jump_target  (jump_target),
        .btb_pc       (btb_pc),
        .btb_next     (btb_next),
        .btb_pred     (btb_pred),
        .mem          (mem_bus),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_pred    (inst_pred),
        .inst_pred_pc (inst_pred_pc)
    );

    // Branch buffer model: predicted target when taken, else the next word.
    assign btb_next = btb_pred ? btb_tgt : btb_pc + 32'd4;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 8'h13;
            32'h0000_0001: return 8'h05;
            32'h0000_0002: return 8'h10;
            32'h0000_0003: return 8'h00;
            32'h0000_0008: return 8'h37;
            32'h0000_0009: return 8'h45;
            32'h0000_000A: return 8'h23;
            32'h0000_000B: return 8'h01;
            32'h0000_0040: return 8'h93;
            32'h0000_0041: return 8'h02;
            32'h0000_0042: return 8'h50;
            32'h0000_0043: return 8'h00;
            32'h0000_0100: return 8'hB3;
            32'h0000_0101: return 8'h03;
            32'h0000_0102: return 8'h73;
            32'h0000_0103: return 8'h00;
            32'hFFFF_FFFC: return 8'hEF;
            32'hFFFF_FFFD: return 8'hBE;
            32'hFFFF_FFFE: return 8'hAD;
            32'hFFFF_FFFF: return 8'hDE;
            default:       return 8'hEE;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_inst(input logic [31:0] i, input logic [31:0] p,
                             input logic pr, input logic [31:0] pp);
        exp_t e;
        e.inst = i; e.pc = p; e.pred = pr; e.ppc = pp;
        exp_q.push_back(e);
    endtask

    task automatic push_addrs(input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) exp_addr_q.push_back(base + 32'(k));
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!inst_valid && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk(name, 32'(inst_valid), 32'd1);
    endtask

    task automatic accept(input logic pred, input logic [31:0] tgt, input logic [31:0] next_pc);
        @(posedge clock); #1;
        stall = 1'b0; btb_pred = pred; btb_tgt = tgt;
        @(posedge clock); #1;
        stall = 1'b1;
        @(negedge clock);
        chk("handoff_valid", 32'(inst_valid), 32'd0);
        chk("handoff_pc", btb_pc, next_pc);
    endtask

    task automatic do_jump(input logic [31:0] tgt);
        @(posedge clock); #1;
        jump = 1'b1; jump_target = tgt;
        @(posedge clock); #1;
        jump = 1'b0;
        @(negedge clock);
        chk("jump_valid", 32'(inst_valid), 32'd0);
        chk("jump_pc", btb_pc, tgt);
    endtask

    // Memory responder: checks each accepted byte request, answers after resp_delay.
    initial begin
        logic [31:0] a;
        logic [31:0] e;
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_valid = 1'b0;
        mem_bus.mem_data  = 8'h00;
        forever begin
            @(negedge clock);
            if (reset && mem_bus.mem_req && mem_bus.mem_ready) begin
                a = mem_bus.mem_addr;
                if (exp_addr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req actual=%h expected=none", a);
                end else begin
                    e = exp_addr_q.pop_front();
                    chk("mem_addr", a, e);
                end
                repeat (resp_delay) @(posedge clock);
                @(posedge clock); #1;
                mem_bus.mem_valid = 1'b1;
                mem_bus.mem_data  = mem_byte(a);
                @(posedge clock); #1;
                mem_bus.mem_valid = 1'b0;
            end
        end
    end

    // Monitor: each newly presented instruction is checked against the queue.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clock);
            if (reset && inst_valid && !prev) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_inst actual=%h expected=none", inst);
                end else begin
                    e = exp_q.pop_front();
                    chk("inst", inst, e.inst);
                    chk("inst_pc", inst_pc, e.pc);
                    chk("inst_pred", 32'(inst_pred), 32'(e.pred));
                    chk("inst_pred_pc", inst_pred_pc, e.ppc);
                end
            end
            prev = reset && inst_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b1; stall = 1'b1; jump = 1'b0; jump_target = 32'd0;
        btb_pred = 1'b1; btb_tgt = 32'h40;
        #2 reset = 1'b0;
        #1;
        chk("rst_async_valid", 32'(inst_valid), 32'd0);
        chk("rst_async_inst", inst, 32'd0);
        chk("rst_async_pc", btb_pc, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_inst_pred", 32'(inst_pred), 32'd0);
        chk("rst_inst_pred_pc", inst_pred_pc, 32'd0);
        chk("rst_mem_req", 32'(mem_bus.mem_req), 32'd0);

        // First fetch from 0, predicted taken to 0x40.
        push_addrs(32'h0, 4);
        push_inst(32'h0010_0513, 32'h0, 1'b1, 32'h40);
        @(posedge clock); #1;
        reset = 1'b1;
        n = 0;
        do begin
            @(posedge clock);
            @(negedge clock);
            n++;
        end while (!inst_valid && n < 40);
        chk("first_latency", 32'(n), 32'd8);

        // Stall in HOLD: everything stays put, no requests.
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            @(negedge clock);
            chk("stall_valid", 32'(inst_valid), 32'd1);
            chk("stall_inst", inst, 32'h0010_0513);
            chk("stall_inst_pc", inst_pc, 32'h0);
            chk("stall_req", 32'(mem_bus.mem_req), 32'd0);
        end

        // Handoff follows the prediction to 0x40; next one predicts 0xFFFFFFFC.
        push_addrs(32'h40, 4);
        push_inst(32'h0050_0293, 32'h40, 1'b1, 32'hFFFF_FFFC);
        accept(1'b1, 32'hFFFF_FFFC, 32'h40);
        wait_valid("wait_0x40");

        // Fetch at the top of the address space; sequential successor wraps to 0.
        push_addrs(32'hFFFF_FFFC, 4);
        push_inst(32'hDEAD_BEEF, 32'hFFFF_FFFC, 1'b0, 32'h0);
        accept(1'b0, 32'h0, 32'hFFFF_FFFC);
        wait_valid("wait_wrap");

        if (!CACHE_ON) push_addrs(32'h0, 4);
        push_inst(32'h0010_0513, 32'h0, 1'b0, 32'h4);
        accept(1'b0, 32'h0, 32'h0);
        wait_valid("wait_refetch0");

        // Jump while a byte is in flight: byte dropped, refetch from 0x100.
        resp_delay = 1;
        push_addrs(32'h8, 3);
        push_addrs(32'h100, 4);
        push_inst(32'h0073_03B3, 32'h100, 1'b0, 32'h104);
        do_jump(32'h8);
        n = 0;
        while (!(mem_bus.mem_req && mem_bus.mem_addr == 32'hA) && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("req_0xA_seen", 32'(n < 100), 32'd1);
        @(posedge clock); #1;
        jump = 1'b1; jump_target = 32'h100;
        @(posedge clock); #1;
        jump = 1'b0;
        @(negedge clock);
        chk("drop_no_req", 32'(mem_bus.mem_req), 32'd0);
        chk("drop_pc", btb_pc, 32'h100);
        wait_valid("wait_0x100");

        // Jump coinciding with a returned byte: byte ignored, no drop pending.
        resp_delay = 0;
        push_addrs(32'h8, 2);
        if (!CACHE_ON) push_addrs(32'h40, 4);
        push_inst(32'h0050_0293, 32'h40, 1'b0, 32'h44);
        do_jump(32'h8);
        n = 0;
        while (!(mem_bus.mem_req && mem_bus.mem_addr == 32'h9) && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("req_0x9_seen", 32'(n < 100), 32'd1);
        @(posedge clock); #1;
        jump = 1'b1; jump_target = 32'h40;
        @(posedge clock); #1;
        jump = 1'b0;
        @(negedge clock);
        chk("same_cycle_pc", btb_pc, 32'h40);
        wait_valid("wait_0x40_again");

`ifdef IF_ICACHE_EN
        // Fill line 0x8, then refetch it from the cache in one cycle.
        push_addrs(32'h8, 4);
        push_inst(32'h0123_4537, 32'h8, 1'b0, 32'hC);
        do_jump(32'h8);
        wait_valid("wait_fill8");
        push_inst(32'h0123_4537, 32'h8, 1'b0, 32'hC);
        do_jump(32'h8);
        chk("hit_no_req", 32'(mem_bus.mem_req), 32'd0);
        @(negedge clock);
        chk("hit_valid", 32'(inst_valid), 32'd1);
`endif

        repeat (4) @(negedge clock);
        chk("inst_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
